// File: rtl/epu_spad_bank.sv
// epu_spad_bank: single-port scratchpad bank behind sp_ram_intf.
// The compute port (cs/oe/W_req/addr) has one-cycle registered reads and always wins.
// The host port (valid/ready) only uses cycles where cs=0. Reads go through a 1-entry
// response register.
// Optional feature: define SPAD_ZERO_INIT_EN to zero the array after every reset.
// In that build init_done stays low for DEPTH cycles after reset release.

`ifndef WRITE_ENB
`define WRITE_ENB 1'b0
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 1'b1
`endif

module epu_spad_bank #(
    parameter int DEPTH = 4096,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    // compute port
    input  logic          cs,
    input  logic          oe,
    input  logic          W_req,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] W_data,
    output logic [DW-1:0] R_data,
    // host port
    input  logic          host_req_valid,
    output logic          host_req_ready,
    input  logic          host_we,
    input  logic [31:0]   host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_rsp_valid,
    input  logic          host_rsp_ready,
    output logic [DW-1:0] host_rdata,
    // status
    output logic          oor_err,
    output logic          init_done
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic          sweep_we;
    logic [AW-1:0] sweep_idx;

`ifdef SPAD_ZERO_INIT_EN
    logic          init_done_q;

    // Zeroing sweep: one entry per cycle after reset release, restarted by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx   <= '0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            if (sweep_idx == AW'(DEPTH - 1)) begin
                init_done_q <= 1'b1;
            end else begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    assign sweep_we  = ~rst & ~init_done_q;
    assign init_done = init_done_q;
`else
    assign sweep_we  = 1'b0;
    assign sweep_idx = '0;
    assign init_done = 1'b1;
`endif

    // Access decode. Host only runs when cs=0, so both ports can share one read mux.
    logic          comp_acc, comp_wr, comp_rd, comp_oor;
    logic          host_acc, host_wr, host_rd, host_oor;
    logic          rsp_full;
    logic [DW-1:0] rsp_data;
    logic [DW-1:0] r_data_q;
    logic [AW-1:0] rd_idx;
    logic          rd_oor;
    logic [DW-1:0] rd_word;

    assign comp_oor = (addr >= 32'(DEPTH));
    assign host_oor = (host_addr >= 32'(DEPTH));

    assign comp_acc = cs & init_done & ~rst;
    assign comp_wr  = comp_acc & (W_req == `WRITE_ENB);
    assign comp_rd  = comp_acc & (W_req == `WRITE_DIS);

    // Combinational from cs, so compute wins any same-cycle collision.
    assign host_req_ready = init_done & ~cs & ~rst & (host_we | ~rsp_full | host_rsp_ready);
    assign host_acc       = host_req_valid & host_req_ready;
    assign host_wr        = host_acc & host_we;
    assign host_rd        = host_acc & ~host_we;

    assign rd_idx  = cs ? addr[AW-1:0] : host_addr[AW-1:0];
    assign rd_oor  = cs ? comp_oor : host_oor;
    assign rd_word = rd_oor ? '0 : mem[rd_idx];

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] wr_data;

    // Write-port arbitration: sweep, then compute, then host. Out-of-range writes are dropped.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_en   = 1'b0;
        wr_idx  = addr[AW-1:0];
        wr_data = W_data;
        if (sweep_we) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_idx;
            wr_data = '0;
        end else if (comp_wr) begin
            wr_en   = ~comp_oor;
        end else if (host_wr) begin
            wr_en   = ~host_oor;
            wr_idx  = host_addr[AW-1:0];
            wr_data = host_wdata;
        end
    end

    // Array write at the clock edge. A read in the following cycle sees the new data.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it can map onto SRAM. Clearing it is the sweep's job.
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Compute read register: loads only on a compute read and otherwise holds.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_data_q <= '0;
        end else if (comp_rd) begin
            r_data_q <= rd_word;
        end
    end

    assign R_data = oe ? r_data_q : '0;

    // Host response slot: reloads on an accepted read, empties when drained with no new read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_full <= 1'b0;
            rsp_data <= '0;
        end else if (host_rd) begin
            rsp_full <= 1'b1;
            rsp_data <= rd_word;
        end else if (host_rsp_ready) begin
            rsp_full <= 1'b0;
        end
    end

    assign host_rsp_valid = rsp_full;
    assign host_rdata     = rsp_data;

    // Sticky out-of-range flag for any accepted access on either port.
    always_ff @(posedge clk) begin
        if (rst) begin
            oor_err <= 1'b0;
        end else if ((comp_acc & comp_oor) | (host_acc & host_oor)) begin
            oor_err <= 1'b1;
        end
    end

endmodule

// File: doc/epu_spad_bank.md
# epu_spad_bank

Single-port scratchpad bank that sits on the memory side of `sp_ram_intf`. It answers the EPU compute engine's `cs`/`oe`/`W_req`/`addr` requests with fixed one-cycle read latency and never stalls it. A secondary host port uses a valid/ready handshake; the DMA/CPU wrapper uses it to load parameters, bias, weights and inputs and to drain outputs. The compute port always has priority, and the host port only uses idle cycles.

## Interface
- `DEPTH`, 4096: number of words; the index is `addr[$clog2(DEPTH)-1:0]`.
- `DW`, 32: word width.
- `clk  in  1`: sole clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `cs  in  1`: compute chip select.
- `oe  in  1`: compute output enable; `R_data` is forced to 0 while `oe`=0.
- `W_req  in  1`: `` `WRITE_ENB `` writes, `` `WRITE_DIS `` reads (encodings from `ConvAcc.svh`).
- `addr  in  32`: compute word address.
- `W_data  in  DW`: compute write data.
- `R_data  out  DW`: compute read data, registered.
- `host_req_valid  in  1`: host request valid.
- `host_req_ready  out  1`: host request accepted this cycle.
- `host_we  in  1`: 1 = write, 0 = read.
- `host_addr  in  32`: host word address.
- `host_wdata  in  DW`: host write data.
- `host_rsp_valid  out  1`: read response valid.
- `host_rsp_ready  in  1`: host consumes the response.
- `host_rdata  out  DW`: read response data.
- `oor_err  out  1`: sticky flag; set when any accepted access has `addr >= DEPTH`.
- `init_done  out  1`: array usable (see Configuration).

## Operation
- **Compute access** happens when `cs`=1 and `init_done`=1.
  - Write: `mem[idx] <= W_data`; the `R_data` register holds its value.
  - Read: the `R_data` register loads `mem[idx]` at the clock edge.
- **Compute idle** (`cs`=0): the `R_data` register holds its last value. The engine relies on reading the value again later.
- **Host acceptance:** `host_req_ready = init_done & ~cs & (host_we | ~rsp_full | host_rsp_ready)`. This is combinational from `cs`, so compute always wins a same-cycle collision.
- **Host write accepted:** the write to `mem[idx]` takes effect at the same edge. No response is produced.
- **Host read accepted:** a 1-entry response register loads `mem[idx]` and sets `rsp_full`.
  - `rsp_full` clears when `host_rsp_ready`=1 and no new read is accepted in that cycle.
  - Accept and drain in the same cycle: the register reloads and stays full.
- `host_rsp_valid` equals `rsp_full`.
- `host_rdata` is stable while `host_rsp_valid`=1 and `host_rsp_ready`=0.
- **Out of range** (`addr >= DEPTH`, either port):
  - write: dropped;
  - read: returns 0;
  - in both cases `oor_err` is set; only `rst` clears it.
- Read-after-write to the same address on consecutive cycles returns the new data. There is no bypass, and none is needed, because the array writes at the edge.

## Timing
- Compute read: `addr` is sampled at edge N; `R_data` is valid after edge N and holds until the next compute read.
- Host read: accepted at edge N; `host_rsp_valid`=1 after edge N.
- Sustained host read throughput is 1 per cycle while `host_rsp_ready`=1 and `cs`=0.
- Host write: visible to either port's read from edge N+1 onward.
- Reset values:
  - `R_data`, `host_rdata`, `host_rsp_valid`, `oor_err` = 0.
  - `host_req_ready` = 0 while `rst`=1.
  - `init_done`: 0 with the macro, 1 without.
- Reset in the middle of a transfer drops the pending response. Array contents are not touched by `rst` unless the macro is defined.

## Configuration
- `SPAD_ZERO_INIT_EN` defined:
  - After `rst` deasserts, an internal counter writes 0 to entries 0..DEPTH-1, one per cycle.
  - `init_done` rises on the cycle after entry DEPTH-1 is written, i.e. DEPTH cycles after reset release.
  - During the sweep, compute accesses are ignored (`R_data` holds 0) and `host_req_ready`=0.
  - `rst` asserted during the sweep restarts it from entry 0.
- `SPAD_ZERO_INIT_EN` not defined: no sweep logic, `init_done` is tied to 1, and array contents after power-up are undefined.

## Test plan
- **Compute write/read:** `cs`=1, `W_req`=`` `WRITE_ENB ``, `addr`=5, `W_data`=0x1234, then a read of `addr`=5 → `R_data`=0x1234 one cycle after the read. Then `cs`=0 for 3 cycles → `R_data` stays 0x1234.
- **Collision:** `cs`=1 and `host_req_valid`=1 in the same cycle → `host_req_ready`=0 and the host request is not performed. Next cycle, with `cs`=0 → accepted.
- **Response backpressure:** host reads addr 7 (holding 0xA5), then addr 8 with `host_rsp_ready`=0 → second request gets `host_req_ready`=0 and `host_rdata`=0xA5 stays stable. Raise `host_rsp_ready` → addr 8 is accepted in the same cycle.
- **Out of range:** host writes 0xFF to addr `DEPTH`, then reads it → response is 0, `oor_err`=1, and it stays 1 until `rst`.
- **oe gating:** after a compute read of 0x77, drive `oe`=0 → `R_data`=0; drive `oe`=1 → `R_data`=0x77.
- **With `SPAD_ZERO_INIT_EN`:**
  - Preload addr 3 with 0xDEAD via the host port, then pulse `rst` → `init_done`=0 for exactly DEPTH cycles.
  - After `init_done` rises, a read of addr 3 returns 0.
  - Assert `rst` halfway through the sweep → the sweep restarts, and `init_done` rises DEPTH cycles after the release.
